// File: rtl/line_queue.sv
// Segment FIFO feeding a line drawer: queues endpoint pairs, launches one at a
// time with a go pulse, waits for draw_done or a timeout before the next launch.
module line_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [9:0]               wr_stax,
    input  logic [9:0]               wr_stay,
    input  logic [9:0]               wr_endx,
    input  logic [9:0]               wr_endy,
    input  logic                     pause,
    input  logic                     draw_done,
    input  logic                     clr_err,
    output logic                     go,
    output logic [9:0]               stax,
    output logic [9:0]               stay,
    output logic [9:0]               endx,
    output logic [9:0]               endy,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0]   PTR_ONE   = 1;
    localparam logic [CNTW-1:0] CNT_ONE   = 1;
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DEPTH);
    localparam logic [TW-1:0]   TW_ONE    = 1;
    localparam logic [TW-1:0]   WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GO,
        ST_WAIT
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [TW-1:0]   wait_cnt_reg;
    logic [TW-1:0]   wait_cnt_next;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [39:0]     mem [DEPTH];
    logic [39:0]     head;
    logic            push_ok;
    logic            pop;
    logic            timeout_hit;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign push_ok = wr_en && !full;
    assign head    = mem[rd_ptr_reg];

    // Storage has no reset: pointers and count define which entries are valid.
    always_ff @(posedge pclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= {wr_stax, wr_stay, wr_endx, wr_endy};
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        pop           = 1'b0;
        timeout_hit   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty && !pause) begin
                    pop        = 1'b1;
                    state_next = ST_GO;
                end
            end
            ST_GO: state_next = ST_WAIT;
            ST_WAIT: begin
                // draw_done takes priority over an expiring counter
                if (draw_done) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + TW_ONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        go   = (state_reg == ST_GO);
        busy = (state_reg != ST_IDLE);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count        <= '0;
            stax         <= '0;
            stay         <= '0;
            endx         <= '0;
            endy         <= '0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg             <= rd_ptr_reg + PTR_ONE;
                {stax, stay, endx, endy} <= head;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // Set conditions win over a same-cycle clear.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_queue.sv
// Directed bench for line_queue: launch latency, overflow, drain order and
// spacing, timeout, error clearing and mid-segment reset.
module tb_line_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        pclk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [9:0]  wr_stax, wr_stay, wr_endx, wr_endy;
    logic        pause, draw_done, clr_err;
    logic        go, busy, full, empty, overflow, timeout_err;
    logic [9:0]  stax, stay, endx, endy;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [39:0] seg [5];

    always #5 pclk = ~pclk;

    line_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .rst(rst), .wr_en(wr_en),
        .wr_stax(wr_stax), .wr_stay(wr_stay), .wr_endx(wr_endx), .wr_endy(wr_endy),
        .pause(pause), .draw_done(draw_done), .clr_err(clr_err),
        .go(go), .stax(stax), .stay(stay), .endx(endx), .endy(endy),
        .busy(busy), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [39:0] s);
        wr_en = 1'b1;
        {wr_stax, wr_stay, wr_endx, wr_endy} = s;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (go !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, {63'd0, go}, 64'd1);
    endtask

    initial begin
        int k;
        int t_last;
        int go_seen;
        seg[0] = {10'd1,  10'd2,  10'd3,  10'd4};
        seg[1] = {10'd11, 10'd12, 10'd13, 10'd14};
        seg[2] = {10'd21, 10'd22, 10'd23, 10'd24};
        seg[3] = {10'd31, 10'd32, 10'd33, 10'd34};
        seg[4] = {10'd41, 10'd42, 10'd43, 10'd44};

        rst = 1'b1; wr_en = 1'b0; pause = 1'b0; draw_done = 1'b0; clr_err = 1'b0;
        {wr_stax, wr_stay, wr_endx, wr_endy} = '0;
        tick(); tick();
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_go",    {63'd0, go}, 64'd0);
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_full",  {63'd0, full}, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_data",  {24'd0, stax, stay, endx, endy}, 64'd0);
        check("rst_errs",  {62'd0, overflow, timeout_err}, 64'd0);
        rst = 1'b0;
        tick();

        // launch latency from a single push into an empty queue
        push({10'd10, 10'd20, 10'd300, 10'd400});
        check("lat_go_early", {63'd0, go}, 64'd0);
        check("lat_count1", {61'd0, count}, 64'd1);
        tick();
        check("lat_go", {63'd0, go}, 64'd1);
        check("lat_data", {24'd0, stax, stay, endx, endy},
              {24'd0, 10'd10, 10'd20, 10'd300, 10'd400});
        check("lat_busy", {63'd0, busy}, 64'd1);
        check("lat_count0", {61'd0, count}, 64'd0);
        tick();
        check("lat_go_once", {63'd0, go}, 64'd0);
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        check("done_idle", {63'd0, busy}, 64'd0);

        // timeout: GO cycle plus 16 WAIT cycles before busy drops
        push(seg[0]);
        wait_go("to_go");
        k = 0;
        do begin
            tick();
            k++;
        end while (busy && k < 40);
        check("to_cycles", 64'(k), 64'd17);
        check("to_err", {63'd0, timeout_err}, 64'd1);
        check("to_data_hold", {24'd0, stax, stay, endx, endy}, {24'd0, seg[0]});
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("to_clr", {63'd0, timeout_err}, 64'd0);

        // draw_done on the last WAIT cycle beats the timeout
        push(seg[1]);
        wait_go("dd16_go");
        repeat (16) tick();
        check("dd16_busy", {63'd0, busy}, 64'd1);
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        check("dd16_idle", {63'd0, busy}, 64'd0);
        check("dd16_noerr", {63'd0, timeout_err}, 64'd0);

        // fill under pause, fifth push overflows
        pause = 1'b1;
        for (int i = 0; i < 4; i++) push(seg[i]);
        check("fill_count", {61'd0, count}, 64'd4);
        check("fill_full", {63'd0, full}, 64'd1);
        check("fill_noovf", {63'd0, overflow}, 64'd0);
        push(seg[4]);
        check("ovf_set", {63'd0, overflow}, 64'd1);
        check("ovf_count", {61'd0, count}, 64'd4);
        check("pause_nogo", {63'd0, busy}, 64'd0);
        wr_en = 1'b1; clr_err = 1'b1; tick(); wr_en = 1'b0; clr_err = 1'b0;
        check("ovf_clr_lose", {63'd0, overflow}, 64'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("ovf_clr", {63'd0, overflow}, 64'd0);

        // drain in order, draw_done 5 cycles after each go
        pause = 1'b0;
        t_last = 0;
        for (int g = 0; g < 4; g++) begin
            wait_go($sformatf("drain_go%0d", g));
            check($sformatf("drain_data%0d", g), {24'd0, stax, stay, endx, endy}, {24'd0, seg[g]});
            if (g > 0) check($sformatf("drain_space%0d", g), 64'(cyc - t_last), 64'd7);
            t_last = cyc;
            repeat (5) tick();
            draw_done = 1'b1; tick(); draw_done = 1'b0;
        end
        check("drain_busy", {63'd0, busy}, 64'd0);
        check("drain_empty", {63'd0, empty}, 64'd1);
        go_seen = 0;
        repeat (6) begin
            tick();
            if (go) go_seen++;
        end
        check("drain_no5th", 64'(go_seen), 64'd0);

        // dropped push while full, same cycle as a pop
        pause = 1'b1;
        for (int i = 0; i < 4; i++) push(seg[i]);
        pause = 1'b0;
        push(seg[4]);
        check("popovf_go", {63'd0, go}, 64'd1);
        check("popovf_count", {61'd0, count}, 64'd3);
        check("popovf_ovf", {63'd0, overflow}, 64'd1);
        tick();
        check("mid_busy", {63'd0, busy}, 64'd1);

        // asynchronous reset in WAIT with entries queued
        rst = 1'b1;
        #1;
        check("mr_busy", {63'd0, busy}, 64'd0);
        check("mr_count", {61'd0, count}, 64'd0);
        check("mr_empty", {62'd0, empty, full}, 64'd2);
        check("mr_data", {24'd0, stax, stay, endx, endy}, 64'd0);
        check("mr_errs", {62'd0, overflow, timeout_err}, 64'd0);
        tick();
        rst = 1'b0;
        go_seen = 0;
        repeat (10) begin
            tick();
            if (go) go_seen++;
        end
        check("mr_nogo", 64'(go_seen), 64'd0);
        push(seg[2]);
        tick();
        check("mr_new_go", {63'd0, go}, 64'd1);
        check("mr_new_data", {24'd0, stax, stay, endx, endy}, {24'd0, seg[2]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_queue.md
LINE_QUEUE -- requirements
Module: line_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 1048576, max pclk cycles in WAIT before abort.
REQ-003 pclk  in  1  pixel clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  push one line segment when high for one cycle.
REQ-006 wr_stax, wr_stay, wr_endx, wr_endy  in  10 each  segment endpoints to push.
REQ-007 pause  in  1  inhibits launch of a new segment (a running segment completes).
REQ-008 draw_done  in  1  one-cycle completion pulse from the downstream line drawer.
REQ-009 clr_err  in  1  clears the sticky overflow and timeout flags.
REQ-010 go  out  1  one-cycle launch pulse to the line drawer.
REQ-011 stax, stay, endx, endy  out  10 each  registered endpoints of the active segment.
REQ-012 busy  out  1  high while a segment is launched and not yet finished.
REQ-013 full, empty  out  1 each  FIFO status.
REQ-014 count  out  $clog2(DEPTH)+1  entries held in the FIFO.
REQ-015 overflow, timeout_err  out  1 each  sticky error flags.

Function
REQ-016 FIFO entry = {stax,stay,endx,endy}, 40 bits; circular read/write pointers wrap modulo DEPTH.
REQ-017 Push accepted when wr_en=1 and full=0; count, full and empty update at the next edge.
REQ-018 Push with full=1 is dropped; overflow sets at the next edge, even if a pop occurs that same cycle.
REQ-019 FSM states: IDLE, GO, WAIT.
REQ-020 IDLE -> GO when empty=0 and pause=0; on that edge the head entry loads into the stax..endy registers and is popped.
REQ-021 GO: go=1 for exactly this cycle; unconditional GO -> WAIT at the next edge.
REQ-022 WAIT -> IDLE on draw_done=1; draw_done is ignored in IDLE and GO.
REQ-023 WAIT -> IDLE with timeout_err set when the WAIT cycle counter reaches TIMEOUT-1 without draw_done.
REQ-024 If draw_done and timeout expiry coincide, draw_done wins: timeout_err is not set.
REQ-025 WAIT counter clears on entry to WAIT and is TIMEOUT-bit-width sufficient; it never wraps.
REQ-026 busy = (state != IDLE); go = (state == GO); both decoded from the state register only.
REQ-027 stax..endy hold their value from the load edge until the next load; they are unchanged in IDLE.
REQ-028 Simultaneous push and pop when not full: both take effect, count unchanged.
REQ-029 Push into empty FIFO in IDLE: go asserts 2 cycles after the wr_en cycle (push edge, load edge, go cycle).
REQ-030 Back-to-back segments: the next IDLE -> GO occurs the cycle after WAIT -> IDLE; minimum spacing between go pulses is 3 cycles.
REQ-031 pause raised in GO or WAIT has no effect on the running segment; it only holds IDLE.
REQ-032 clr_err clears both sticky flags at the next edge; a same-cycle set condition wins over clr_err.

Reset
REQ-033 While rst=1: state=IDLE, pointers and count=0, empty=1, full=0, go=0, busy=0, stax..endy=0, overflow=0, timeout_err=0, WAIT counter=0.
REQ-034 rst asserted mid-segment aborts immediately; queued entries are discarded; no go pulse issues until after rst deasserts.

Verification
REQ-035 Push (10,20,300,400) into empty, pause=0 -> go high exactly 2 cycles later, stax=10, stay=20, endx=300, endy=400, busy=1, count=0.
REQ-036 Push 5 segments back-to-back with pause=1, DEPTH=4 -> count=4, full=1, overflow=1 after 5th push, 5th segment never appears on outputs.
REQ-037 4 queued, pause=0, draw_done returned 5 cycles after each go -> 4 go pulses in push order, spacing 7 cycles, final empty=1, busy=0.
REQ-038 TIMEOUT=16, no draw_done -> busy drops after 16 WAIT cycles, timeout_err=1; draw_done on cycle 16 instead -> timeout_err=0.
REQ-039 rst pulsed while in WAIT with 2 entries queued -> all outputs at REQ-033 values, no go after release until a new push.
REQ-040 overflow=1, clr_err pulsed -> overflow=0 next cycle; clr_err coincident with a dropped push -> overflow stays 1.
